rx_acl_key_unpack: RTL and testbench
====================================

RX_ACL_KEY_UNPACK -- requirements
Module: rx_acl_key_unpack

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, meaning key-buffer entries (power of two, 2..16).
REQ-002 Port i_clk  input  1  250 MHz system clock; all logic SHALL be on its rising edge.
REQ-003 Port i_rst  input  1  reset, synchronous and active-high.
REQ-004 Port i_mac_cross_port_axi_data  input  144  packed lookup key.
REQ-005 Port i_mac_cross_axi_data_valid  input  1  key valid, one cycle per key, no back-pressure.
REQ-006 Port i_key_rdy  input  1  downstream ACL engine ready.
REQ-007 Port o_key_vld  output  1  unpacked key presented.
REQ-008 Port o_dmac_data  output  48  destination MAC.
REQ-009 Port o_smac_data  output  48  source MAC.
REQ-010 Port o_vlan_pri  output  3  VLAN priority.
REQ-011 Port o_vlan_id  output  12  VLAN ID.
REQ-012 Port o_ethertyper  output  16  EtherType.
REQ-013 Port o_tpid_err  output  1  key TPID not 0x8100 or CFI set; qualified by o_key_vld.
REQ-014 Port o_fifo_full  output  1  key buffer holds FIFO_DEPTH entries.
REQ-015 Port o_drop_cnt  output  16  count of keys discarded on overflow.

Function
REQ-016 Key field map SHALL be: [143:96] DMAC, [95:48] SMAC, [47:32] TPID, [31:29] PRI, [28] CFI, [27:16] VID, [15:0] EtherType.
REQ-017 A valid key SHALL be written to the FIFO when the FIFO is not full, or when full and a FIFO pop occurs in the same cycle.
REQ-018 A valid key arriving when full with no same-cycle pop SHALL be discarded and o_drop_cnt incremented, saturating at 0xFFFF.
REQ-019 Output stage SHALL be an FSM with states IDLE (o_key_vld=0) and PRESENT (o_key_vld=1).
REQ-020 IDLE -> PRESENT when FIFO non-empty; the head entry SHALL be popped and registered into the output fields.
REQ-021 PRESENT with i_key_rdy=1 and FIFO non-empty SHALL pop and load the next key, remaining PRESENT (one key per cycle throughput).
REQ-022 PRESENT with i_key_rdy=1 and FIFO empty -> IDLE.
REQ-023 PRESENT with i_key_rdy=0 SHALL hold all output fields and o_key_vld stable.
REQ-024 Latency: key valid in cycle t with FIFO empty and FSM IDLE SHALL give o_key_vld=1 in cycle t+2.
REQ-025 Total buffering SHALL be FIFO_DEPTH entries plus the output register; key order SHALL be preserved.
REQ-026 o_tpid_err SHALL be registered with the key fields and computed from the stored TPID/CFI.
REQ-027 Output fields SHALL retain the last presented key when IDLE.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width SHALL be clog2(FIFO_DEPTH)+1.

Reset
REQ-029 i_rst=1 SHALL force: FSM IDLE, FIFO empty, o_key_vld=0, all field outputs 0, o_tpid_err=0, o_fifo_full=0, o_drop_cnt=0.
REQ-030 Reset asserted mid-transfer SHALL discard all buffered and presented keys; no key SHALL appear after deassertion unless newly written.
REQ-031 Input valid during a reset cycle SHALL be ignored.

Structure
REQ-032 Field bit positions, TPID constant 16'h8100 and key width 144 SHALL live in a shared package used with the RX key packer.
REQ-033 Key storage SHALL be a sub-module sync_fifo_144 (parameterised depth, show-ahead, full/empty flags); FSM and counters in the top.

Verification
REQ-034 Single key DMAC=0x001122334455, SMAC=0x66778899AABB, PRI=5, VID=0x064, EtherType=0x0800, i_key_rdy=1 -> o_key_vld in t+2, fields exact, o_tpid_err=0.
REQ-035 Key with TPID=0x88A8 -> o_tpid_err=1 with that key only; following 0x8100 key -> o_tpid_err=0.
REQ-036 i_key_rdy=0, 7 back-to-back keys, FIFO_DEPTH=4 -> o_fifo_full=1, o_drop_cnt=2; after rdy=1 exactly 5 keys out in order.
REQ-037 FIFO full with rdy=1 and new key same cycle -> key accepted, o_drop_cnt unchanged.
REQ-038 10 back-to-back keys, rdy=1 constant -> 10 consecutive o_key_vld cycles, no gaps.
REQ-039 i_rst pulse while 3 keys buffered and one presented -> o_key_vld=0 next cycle, nothing output until new key written.

Source files
------------

// File: rtl/rx_acl_key_unpack_pkg.sv
// Shared key layout for the RX ACL key packer/unpacker pair.
// Field positions, VLAN TPID constant and key width live here so both ends agree.
package rx_acl_key_unpack_pkg;

   localparam int KEY_W = 144;

   localparam int DMAC_MSB  = 143;
   localparam int DMAC_LSB  = 96;
   localparam int SMAC_MSB  = 95;
   localparam int SMAC_LSB  = 48;
   localparam int TPID_MSB  = 47;
   localparam int TPID_LSB  = 32;
   localparam int PRI_MSB   = 31;
   localparam int PRI_LSB   = 29;
   localparam int CFI_BIT   = 28;
   localparam int VID_MSB   = 27;
   localparam int VID_LSB   = 16;
   localparam int ETYPE_MSB = 15;
   localparam int ETYPE_LSB = 0;

   localparam logic [15:0] TPID_VLAN = 16'h8100;

   typedef struct packed {
      logic [47:0] dmac;
      logic [47:0] smac;
      logic [15:0] tpid;
      logic [2:0]  pri;
      logic        cfi;
      logic [11:0] vid;
      logic [15:0] ethertype;
   } acl_key_t;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } out_state_e;

   function automatic acl_key_t unpack_key(input logic [KEY_W-1:0] raw);
      acl_key_t k;
      k.dmac      = raw[DMAC_MSB:DMAC_LSB];
      k.smac      = raw[SMAC_MSB:SMAC_LSB];
      k.tpid      = raw[TPID_MSB:TPID_LSB];
      k.pri       = raw[PRI_MSB:PRI_LSB];
      k.cfi       = raw[CFI_BIT];
      k.vid       = raw[VID_MSB:VID_LSB];
      k.ethertype = raw[ETYPE_MSB:ETYPE_LSB];
      return k;
   endfunction

   function automatic logic [KEY_W-1:0] pack_key(input acl_key_t k);
      logic [KEY_W-1:0] raw;
      raw                      = '0;
      raw[DMAC_MSB:DMAC_LSB]   = k.dmac;
      raw[SMAC_MSB:SMAC_LSB]   = k.smac;
      raw[TPID_MSB:TPID_LSB]   = k.tpid;
      raw[PRI_MSB:PRI_LSB]     = k.pri;
      raw[CFI_BIT]             = k.cfi;
      raw[VID_MSB:VID_LSB]     = k.vid;
      raw[ETYPE_MSB:ETYPE_LSB] = k.ethertype;
      return raw;
   endfunction

   // A key is malformed when it is not an 802.1Q tag or carries the CFI bit.
   function automatic logic key_tpid_err(input acl_key_t k);
      return (k.tpid != TPID_VLAN) || k.cfi;
   endfunction

endpackage

// File: rtl/rx_acl_key_unpack_if.sv
// Key input bus and unpacked-key output bus of the ACL key unpacker.
interface rx_acl_key_unpack_if;
   import rx_acl_key_unpack_pkg::*;

   logic [KEY_W-1:0] i_mac_cross_port_axi_data;
   logic             i_mac_cross_axi_data_valid;
   logic             i_key_rdy;
   logic             o_key_vld;
   logic [47:0]      o_dmac_data;
   logic [47:0]      o_smac_data;
   logic [2:0]       o_vlan_pri;
   logic [11:0]      o_vlan_id;
   logic [15:0]      o_ethertyper;
   logic             o_tpid_err;
   logic             o_fifo_full;
   logic [15:0]      o_drop_cnt;

   modport master (
      output i_mac_cross_port_axi_data,
      output i_mac_cross_axi_data_valid,
      output i_key_rdy,
      input  o_key_vld,
      input  o_dmac_data,
      input  o_smac_data,
      input  o_vlan_pri,
      input  o_vlan_id,
      input  o_ethertyper,
      input  o_tpid_err,
      input  o_fifo_full,
      input  o_drop_cnt
   );

   modport slave (
      input  i_mac_cross_port_axi_data,
      input  i_mac_cross_axi_data_valid,
      input  i_key_rdy,
      output o_key_vld,
      output o_dmac_data,
      output o_smac_data,
      output o_vlan_pri,
      output o_vlan_id,
      output o_ethertyper,
      output o_tpid_err,
      output o_fifo_full,
      output o_drop_cnt
   );

endinterface

// File: rtl/rx_acl_key_unpack_sync_fifo_144.sv
// Show-ahead synchronous FIFO for 144-bit lookup keys; head entry is visible on rd_data.
// A write into a full FIFO is accepted only when a read happens in the same cycle.
module sync_fifo_144
   import rx_acl_key_unpack_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             wr_en,
   input  logic [KEY_W-1:0] wr_data,
   input  logic             rd_en,
   output logic [KEY_W-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [KEY_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             do_wr;
   logic             do_rd;

   assign full    = (count_reg == CW'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_rd   = rd_en && !empty;
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem[rd_ptr_reg];

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_reg + CW'(do_wr) - CW'(do_rd);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr && !srst) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

endmodule

// File: rtl/rx_acl_key_unpack.sv
// Buffers packed ACL lookup keys and presents them field-by-field to the ACL engine
// through a two-state output register with ready/valid flow control.
module rx_acl_key_unpack
   import rx_acl_key_unpack_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   rx_acl_key_unpack_if.slave bus
);

   out_state_e       state_reg;
   out_state_e       state_next;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_wr;
   logic [KEY_W-1:0] fifo_head;
   acl_key_t         head_key;
   logic             load;
   logic             key_vld;
   logic             drop;

   logic [47:0]      dmac_reg;
   logic [47:0]      smac_reg;
   logic [2:0]       pri_reg;
   logic [11:0]      vid_reg;
   logic [15:0]      etype_reg;
   logic             tpid_err_reg;
   logic [15:0]      drop_cnt_reg;

   // A key may enter a full buffer only if the output stage frees a slot this cycle.
   assign fifo_wr  = bus.i_mac_cross_axi_data_valid && (!fifo_full || load);
   assign drop     = bus.i_mac_cross_axi_data_valid && fifo_full && !load;
   assign head_key = unpack_key(fifo_head);

   sync_fifo_144 #(
      .DEPTH (FIFO_DEPTH)
   ) u_key_fifo (
      .clk     (i_clk),
      .srst    (i_rst),
      .wr_en   (fifo_wr),
      .wr_data (bus.i_mac_cross_port_axi_data),
      .rd_en   (load),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:    if (!fifo_empty) state_next = ST_PRESENT;
         ST_PRESENT: if (bus.i_key_rdy && fifo_empty) state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      key_vld = 1'b0;
      load    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            load = !fifo_empty;
         end
         ST_PRESENT: begin
            key_vld = 1'b1;
            load    = bus.i_key_rdy && !fifo_empty;
         end
         default: begin
            key_vld = 1'b0;
            load    = 1'b0;
         end
      endcase
   end

   // Field registers hold the last presented key while idle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         dmac_reg     <= '0;
         smac_reg     <= '0;
         pri_reg      <= '0;
         vid_reg      <= '0;
         etype_reg    <= '0;
         tpid_err_reg <= 1'b0;
      end else if (load) begin
         dmac_reg     <= head_key.dmac;
         smac_reg     <= head_key.smac;
         pri_reg      <= head_key.pri;
         vid_reg      <= head_key.vid;
         etype_reg    <= head_key.ethertype;
         tpid_err_reg <= key_tpid_err(head_key);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         drop_cnt_reg <= '0;
      end else if (drop && (drop_cnt_reg != 16'hFFFF)) begin
         drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
   end

   assign bus.o_key_vld    = key_vld;
   assign bus.o_dmac_data  = dmac_reg;
   assign bus.o_smac_data  = smac_reg;
   assign bus.o_vlan_pri   = pri_reg;
   assign bus.o_vlan_id    = vid_reg;
   assign bus.o_ethertyper = etype_reg;
   assign bus.o_tpid_err   = tpid_err_reg;
   assign bus.o_fifo_full  = fifo_full;
   assign bus.o_drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_rx_acl_key_unpack.sv
// Directed bench for rx_acl_key_unpack: table of single keys plus overflow, throughput and reset sequences.
module tb_rx_acl_key_unpack;
   import rx_acl_key_unpack_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   passes = 0;

   always #2 clk = ~clk;

   rx_acl_key_unpack_if bus ();

   rx_acl_key_unpack #(
      .FIFO_DEPTH (4)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   typedef struct {
      logic [47:0] dmac;
      logic [47:0] smac;
      logic [15:0] tpid;
      logic [2:0]  pri;
      logic        cfi;
      logic [11:0] vid;
      logic [15:0] et;
      logic        err;
   } vec_t;

   vec_t vecs [6];

   function automatic logic [143:0] mk(input vec_t v);
      return {v.dmac, v.smac, v.tpid, v.pri, v.cfi, v.vid, v.et};
   endfunction

   function automatic logic [126:0] exp_fields(input vec_t v);
      return {v.dmac, v.smac, v.pri, v.vid, v.et};
   endfunction

   function automatic logic [126:0] got_fields();
      return {bus.o_dmac_data, bus.o_smac_data, bus.o_vlan_pri, bus.o_vlan_id, bus.o_ethertyper};
   endfunction

   function automatic vec_t seq_key(input int n);
      vec_t v;
      v.dmac = 48'h0A0B_0C0D_0000 + 48'(n);
      v.smac = 48'h0E0F_1011_0000 + 48'(n);
      v.tpid = 16'h8100;
      v.pri  = 3'(n);
      v.cfi  = 1'b0;
      v.vid  = 12'(n);
      v.et   = 16'h0800;
      v.err  = 1'b0;
      return v;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Consume keys with rdy held high; expects n keys whose VIDs count up from first_id.
   task automatic drain(input int n, input int first_id);
      int got;
      got = 0;
      bus.i_key_rdy = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (bus.o_key_vld) begin
            check("drain_order_vid", 128'(bus.o_vlan_id), 128'(first_id + got));
            got++;
         end
         tick();
      end
      check("drain_count", 128'(got), 128'(n));
   endtask

   initial begin
      vec_t v;
      vecs[0] = '{dmac:48'h001122334455, smac:48'h66778899AABB, tpid:16'h8100, pri:3'd5, cfi:1'b0, vid:12'h064, et:16'h0800, err:1'b0};
      vecs[1] = '{dmac:48'h0000DEADBEEF, smac:48'h123456789ABC, tpid:16'h88A8, pri:3'd2, cfi:1'b0, vid:12'h0A5, et:16'h86DD, err:1'b1};
      vecs[2] = '{dmac:48'hFEDCBA987654, smac:48'h0102030405AA, tpid:16'h8100, pri:3'd0, cfi:1'b0, vid:12'h001, et:16'h0806, err:1'b0};
      vecs[3] = '{dmac:48'h111111111111, smac:48'h222222222222, tpid:16'h8100, pri:3'd3, cfi:1'b1, vid:12'h7FF, et:16'h8847, err:1'b1};
      vecs[4] = '{dmac:48'hFFFFFFFFFFFF, smac:48'hFFFFFFFFFFFF, tpid:16'h8100, pri:3'd7, cfi:1'b0, vid:12'hFFF, et:16'hFFFF, err:1'b0};
      vecs[5] = '{dmac:48'h000000000001, smac:48'h800000000000, tpid:16'h0000, pri:3'd1, cfi:1'b0, vid:12'h000, et:16'h0000, err:1'b1};

      bus.i_mac_cross_port_axi_data  = '0;
      bus.i_mac_cross_axi_data_valid = 1'b0;
      bus.i_key_rdy                  = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      check("rst_vld", 128'(bus.o_key_vld), 128'(0));
      check("rst_fields", 128'(got_fields()), 128'(0));
      check("rst_tpid_err", 128'(bus.o_tpid_err), 128'(0));
      check("rst_full", 128'(bus.o_fifo_full), 128'(0));
      check("rst_drop", 128'(bus.o_drop_cnt), 128'(0));
      rst = 1'b0;
      tick();

      // Single keys, one at a time: latency t+2, exact fields, TPID error, retention when idle.
      for (int i = 0; i < 6; i++) begin
         bus.i_key_rdy = 1'b1;
         bus.i_mac_cross_port_axi_data  = mk(vecs[i]);
         bus.i_mac_cross_axi_data_valid = 1'b1;
         tick();
         bus.i_mac_cross_axi_data_valid = 1'b0;
         check("lat_t1_vld", 128'(bus.o_key_vld), 128'(0));
         tick();
         check("lat_t2_vld", 128'(bus.o_key_vld), 128'(1));
         check("vec_fields", 128'(got_fields()), 128'(exp_fields(vecs[i])));
         check("vec_tpid_err", 128'(bus.o_tpid_err), 128'(vecs[i].err));
         tick();
         check("idle_vld", 128'(bus.o_key_vld), 128'(0));
         check("idle_hold_fields", 128'(got_fields()), 128'(exp_fields(vecs[i])));
      end

      // Overflow: 7 back-to-back keys with rdy low, 1 presented + 4 buffered, 2 dropped.
      bus.i_key_rdy = 1'b0;
      for (int k = 0; k < 7; k++) begin
         bus.i_mac_cross_port_axi_data  = mk(seq_key(k));
         bus.i_mac_cross_axi_data_valid = 1'b1;
         tick();
      end
      bus.i_mac_cross_axi_data_valid = 1'b0;
      tick();
      check("ovf_full", 128'(bus.o_fifo_full), 128'(1));
      check("ovf_drop", 128'(bus.o_drop_cnt), 128'(2));
      check("ovf_vld", 128'(bus.o_key_vld), 128'(1));
      drain(5, 0);
      check("ovf_after_full", 128'(bus.o_fifo_full), 128'(0));
      check("ovf_after_vld", 128'(bus.o_key_vld), 128'(0));

      // Full buffer with rdy and a new key in the same cycle: key accepted, no drop.
      bus.i_key_rdy = 1'b0;
      for (int k = 0; k < 5; k++) begin
         bus.i_mac_cross_port_axi_data  = mk(seq_key(k));
         bus.i_mac_cross_axi_data_valid = 1'b1;
         tick();
      end
      bus.i_mac_cross_axi_data_valid = 1'b0;
      tick();
      check("acc_full", 128'(bus.o_fifo_full), 128'(1));
      check("acc_head_vid", 128'(bus.o_vlan_id), 128'(0));
      bus.i_key_rdy                  = 1'b1;
      bus.i_mac_cross_port_axi_data  = mk(seq_key(5));
      bus.i_mac_cross_axi_data_valid = 1'b1;
      tick();
      bus.i_mac_cross_axi_data_valid = 1'b0;
      check("acc_drop_same", 128'(bus.o_drop_cnt), 128'(2));
      check("acc_still_full", 128'(bus.o_fifo_full), 128'(1));
      drain(5, 1);

      // Ten back-to-back keys with rdy high: o_key_vld high for exactly cycles 2..11.
      bus.i_key_rdy = 1'b1;
      for (int c = 0; c < 14; c++) begin
         check("b2b_vld", 128'(bus.o_key_vld), 128'((c >= 2 && c <= 11) ? 1 : 0));
         if (bus.o_key_vld) check("b2b_vid", 128'(bus.o_vlan_id), 128'(20 + c - 2));
         bus.i_mac_cross_port_axi_data  = mk(seq_key(20 + c));
         bus.i_mac_cross_axi_data_valid = (c < 10);
         tick();
      end
      bus.i_mac_cross_axi_data_valid = 1'b0;

      // Reset with 3 keys buffered and one presented; a key offered during reset is ignored.
      bus.i_key_rdy = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.i_mac_cross_port_axi_data  = mk(seq_key(40 + k));
         bus.i_mac_cross_axi_data_valid = 1'b1;
         tick();
      end
      bus.i_mac_cross_axi_data_valid = 1'b0;
      tick();
      check("prerst_vld", 128'(bus.o_key_vld), 128'(1));
      rst = 1'b1;
      bus.i_mac_cross_port_axi_data  = mk(seq_key(50));
      bus.i_mac_cross_axi_data_valid = 1'b1;
      tick();
      rst = 1'b0;
      bus.i_mac_cross_axi_data_valid = 1'b0;
      check("midrst_vld", 128'(bus.o_key_vld), 128'(0));
      check("midrst_fields", 128'(got_fields()), 128'(0));
      check("midrst_full", 128'(bus.o_fifo_full), 128'(0));
      check("midrst_drop", 128'(bus.o_drop_cnt), 128'(0));
      bus.i_key_rdy = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         check("postrst_quiet", 128'(bus.o_key_vld), 128'(0));
      end
      v = seq_key(60);
      bus.i_mac_cross_port_axi_data  = mk(v);
      bus.i_mac_cross_axi_data_valid = 1'b1;
      tick();
      bus.i_mac_cross_axi_data_valid = 1'b0;
      tick();
      check("postrst_new_vld", 128'(bus.o_key_vld), 128'(1));
      check("postrst_new_fields", 128'(got_fields()), 128'(exp_fields(v)));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
